vend_dispense_ctrl: RTL and testbench
=====================================

Name: vend_dispense_ctrl

Overview:
- Downstream stage of the drink vending FSM. Consumes its one-cycle `drink` pulse and `back` change code.
- Queues each vend/refund event in a small FIFO.
- Sequences the physical actuators one event at a time: the dispense motor and two coin-ejector solenoids (1-yuan, 0.5-yuan).
- Decouples the single-cycle FSM outputs from multi-cycle mechanical timing.

Parameters:
- MOTOR_CYC, 3: cycles the motor stays on per dispensed drink (>=1).
- EJECT_GAP, 2: low cycles after each eject pulse before the next action (>=0).
- DEPTH_LOG2, 2: FIFO depth = 2**DEPTH_LOG2 entries.
- STOCK, 8: initial drink stock; used only with SOLDOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- drink  in  1  vend pulse from the vending FSM.
- back  in  2  change code: 00 none, 01 = 0.5, 10 = 1.0, 11 = 1.5.
- motor  out  1  dispense motor enable.
- eject_1y  out  1  one-cycle pulse that ejects one 1-yuan coin.
- eject_5j  out  1  one-cycle pulse that ejects one 0.5-yuan coin.
- busy  out  1  sequencer not in IDLE.
- pending  out  DEPTH_LOG2+1  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- sold_out  out  1  stock exhausted (tied 0 without SOLDOUT_EN).

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO emptied; state = IDLE; counters cleared.
  - All outputs 0 immediately, including overflow and pending.
  - A mid-operation reset aborts the action in progress; the aborted action is not resumed.
- Event capture, at every rising edge:
  - Any cycle with drink==1 or back!=00 is one event; entry {drink, back} (3 bits) is pushed.
  - drink and back in the same cycle form one entry. Upstream holds an event for exactly one cycle.
  - Push is accepted if pending < depth, or if a pop occurs on the same edge.
  - Otherwise the event is dropped and overflow is set to 1, held until reset.
- Sequencer states: IDLE, MOTOR, EJ1Y, EJ5J, GAP.
- IDLE:
  - If the FIFO is non-empty, pop the head entry and latch it.
  - Next state is the first applicable action in order: MOTOR (drink), EJ1Y (back bit1), EJ5J (back bit0).
  - Entries are never empty, so IDLE always leaves on a pop.
- MOTOR: motor=1 for exactly MOTOR_CYC cycles. Then go to the next applicable action, or IDLE.
- EJ1Y / EJ5J:
  - The corresponding eject output is 1 for exactly one cycle.
  - Then GAP for EJECT_GAP cycles (skipped if 0).
  - Then the next applicable action (EJ5J after EJ1Y), or IDLE.
- Action order for code 11: eject_1y first, then eject_5j.
- Outputs are registered and decoded from state. motor, eject_1y and eject_5j are never high in the same cycle.
- Latency: event on edge E0 is written; popped on edge E1; first actuator cycle follows E1. This holds when the FIFO was empty and state was IDLE.
- After an action sequence completes, the sequencer spends at least one cycle in IDLE before the next pop.
- busy = (state != IDLE).
- pending updates on the same edge as push/pop. Simultaneous push and pop leaves it unchanged.
- The FIFO pointers wrap modulo depth.

Optional Feature:
- Macro: VEND_DISPENSE_SOLDOUT_EN.
- With the macro defined:
  - A stock counter loads STOCK at reset and decrements by 1 at the end of each MOTOR phase.
  - sold_out = (stock==0).
  - A popped entry with drink=1 while stock==0 skips MOTOR. Its change code is replaced by 11, so the full 1.5 price is refunded: eject_1y then eject_5j.
  - The stock counter saturates at 0.
- Without the macro: no stock counter; sold_out is tied 0; every drink entry runs MOTOR.

Test Plan:
- Reset low mid-MOTOR with 2 entries queued -> motor, busy, pending and overflow all 0 immediately. After release, no actuator activity.
- drink=1, back=00 for one cycle, defaults -> motor high exactly 3 cycles starting the cycle after the pop edge; no eject pulses; busy then returns to 0.
- drink=1 with back=01 in one cycle -> motor 3 cycles, then eject_5j 1 cycle, then 2 idle-gap cycles, then IDLE; pending goes 1→0.
- back=11 alone -> eject_1y 1 cycle, 2 gap cycles, eject_5j 1 cycle, 2 gap cycles; busy high 6 cycles total.
- Six back-to-back drink events while the first is being served, depth 4 -> 4 queued, the rest dropped, overflow=1; queued events drain in order with 3-cycle motor bursts.
- With VEND_DISPENSE_SOLDOUT_EN and STOCK=1, two drink events -> first runs motor and sold_out rises; second produces no motor and instead eject_1y then eject_5j.

Source files
------------

// File: rtl/vend_dispense_ctrl.sv
// Actuator sequencer behind the vending FSM: queues {drink, back} events and plays them out
// as motor bursts and coin-eject pulses. Optional stock tracking under VEND_DISPENSE_SOLDOUT_EN.
module vend_dispense_ctrl #(
    parameter int unsigned MOTOR_CYC  = 3,
    parameter int unsigned EJECT_GAP  = 2,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned STOCK      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  drink,
    input  logic [1:0]            back,
    output logic                  motor,
    output logic                  eject_1y,
    output logic                  eject_5j,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   pending,
    output logic                  overflow,
    output logic                  sold_out
);

    localparam int unsigned Depth  = 1 << DEPTH_LOG2;
    localparam int unsigned CntMax = (MOTOR_CYC > EJECT_GAP) ? MOTOR_CYC : EJECT_GAP;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] MotorLast = CntW'(MOTOR_CYC - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'((EJECT_GAP > 0) ? EJECT_GAP - 1 : 0);

    typedef enum logic [2:0] {StIdle, StMotor, StEj1y, StEj5j, StGap} state_e;

    // Action bits are {drink, back[1], back[0]}; the first set bit picks the next phase.
    function automatic state_e first_action(input logic [2:0] act);
        if (act[2]) return StMotor;
        if (act[1]) return StEj1y;
        if (act[0]) return StEj5j;
        return StIdle;
    endfunction

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            act_q, act_d;
    logic [2:0]            mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic                  ev, full, push, pop;
    logic [2:0]            head, entry;
    logic                  stock_dec;

    assign ev   = drink | (|back);
    assign full = (count_q == (DEPTH_LOG2 + 1)'(Depth));
    assign pop  = (state_q == StIdle) && (count_q != '0);
    assign push = ev && (!full || pop);
    assign head = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (ev && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {drink, back};
    end

`ifdef VEND_DISPENSE_SOLDOUT_EN
    localparam int unsigned StockW = (STOCK > 0) ? $clog2(STOCK + 1) : 1;
    logic [StockW-1:0] stock_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stock_q <= StockW'(STOCK);
        end else if (stock_dec && (stock_q != '0)) begin
            stock_q <= stock_q - 1'b1;
        end
    end

    assign sold_out = (stock_q == '0);

    // Out of stock: skip the motor and refund the full 1.5 price.
    always_comb begin
        entry = head;
        if (head[2] && (stock_q == '0)) entry = 3'b011;
    end
`else
    logic unused_stock;
    assign unused_stock = stock_dec ^ (STOCK != 0);
    assign sold_out     = 1'b0;
    assign entry        = head;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_d     = act_q;
        stock_dec = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    act_d   = entry;
                    cnt_d   = '0;
                    state_d = first_action(entry);
                end
            end
            StMotor: begin
                if (cnt_q == MotorLast) begin
                    act_d[2]  = 1'b0;
                    cnt_d     = '0;
                    stock_dec = 1'b1;
                    state_d   = first_action({1'b0, act_q[1:0]});
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StEj1y: begin
                act_d[1] = 1'b0;
                cnt_d    = '0;
                state_d  = (EJECT_GAP > 0) ? StGap : first_action({2'b00, act_q[0]});
            end
            StEj5j: begin
                act_d[0] = 1'b0;
                cnt_d    = '0;
                state_d  = (EJECT_GAP > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = first_action(act_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign motor    = (state_q == StMotor);
    assign eject_1y = (state_q == StEj1y);
    assign eject_5j = (state_q == StEj5j);
    assign busy     = (state_q != StIdle);
    assign pending  = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scoreboard bench for vend_dispense_ctrl: each driven event queues its expected per-cycle
// actuator pattern; a negedge monitor pops and compares while the sequencer is busy.
module tb_vend_dispense_ctrl;

    localparam int unsigned MotorCyc = 3;
    localparam int unsigned EjectGap = 2;
    localparam int unsigned DepthLog2 = 2;
`ifdef VEND_DISPENSE_SOLDOUT_EN
    localparam int unsigned TbStock = 1;
`else
    localparam int unsigned TbStock = 8;
`endif

    logic                 clk;
    logic                 reset;
    logic                 drink;
    logic [1:0]           back;
    logic                 motor, eject_1y, eject_5j, busy, overflow, sold_out;
    logic [DepthLog2:0]   pending;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_stock;
    logic [2:0] sb [$];
    logic [2:0] exp_tok;

    vend_dispense_ctrl #(
        .MOTOR_CYC  (MotorCyc),
        .EJECT_GAP  (EjectGap),
        .DEPTH_LOG2 (DepthLog2),
        .STOCK      (TbStock)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .drink    (drink),
        .back     (back),
        .motor    (motor),
        .eject_1y (eject_1y),
        .eject_5j (eject_5j),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow),
        .sold_out (sold_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected actuator tokens: 100 motor, 010 eject_1y, 001 eject_5j, 000 gap.
    task automatic push_tokens(input logic d, input logic [1:0] b);
        logic       dd;
        logic [1:0] bb;
        dd = d;
        bb = b;
`ifdef VEND_DISPENSE_SOLDOUT_EN
        if (dd) begin
            if (model_stock == 0) begin
                dd = 1'b0;
                bb = 2'b11;
            end else begin
                model_stock--;
            end
        end
`endif
        if (dd) for (int i = 0; i < MotorCyc; i++) sb.push_back(3'b100);
        if (bb[1]) begin
            sb.push_back(3'b010);
            for (int i = 0; i < EjectGap; i++) sb.push_back(3'b000);
        end
        if (bb[0]) begin
            sb.push_back(3'b001);
            for (int i = 0; i < EjectGap; i++) sb.push_back(3'b000);
        end
    endtask

    task automatic send(input logic d, input logic [1:0] b, input bit accept);
        drink = d;
        back  = b;
        if (accept) push_tokens(d, b);
        @(negedge clk);
    endtask

    task automatic quiet();
        drink = 1'b0;
        back  = 2'b00;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, sb.size(), 0);
        check({tag, "_busy_end"}, 32'(busy), 0);
        check({tag, "_pending_end"}, 32'(pending), 0);
`ifdef VEND_DISPENSE_SOLDOUT_EN
        check({tag, "_sold_out"}, 32'(sold_out), 32'(model_stock == 0));
`else
        check({tag, "_sold_out"}, 32'(sold_out), 0);
`endif
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_busy", 32'(busy), 0);
                end else begin
                    exp_tok = sb.pop_front();
                    check("act", 32'({motor, eject_1y, eject_5j}), 32'(exp_tok));
                end
            end else begin
                check("idle_act", 32'({motor, eject_1y, eject_5j}), 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        clk         = 1'b0;
        reset       = 1'b0;
        drink       = 1'b0;
        back        = 2'b00;
        model_stock = TbStock;
        #12;
        check("rst_motor", 32'(motor), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single drink: written at E0, popped at E1, motor from the following cycle.
        send(1'b1, 2'b00, 1'b1);
        quiet();
        check("a_pending_e0", 32'(pending), 1);
        check("a_busy_e0", 32'(busy), 0);
        @(negedge clk);
        check("a_motor_e1", 32'(motor), 1);
        check("a_pending_e1", 32'(pending), 0);
        wait_idle("a");

        // Drink with 0.5 change.
        send(1'b1, 2'b01, 1'b1);
        quiet();
        check("b_pending_e0", 32'(pending), 1);
        @(negedge clk);
        check("b_pending_e1", 32'(pending), 0);
        wait_idle("b");

        // 1.5 refund alone: eject_1y, gap, eject_5j, gap.
        send(1'b0, 2'b11, 1'b1);
        quiet();
        wait_idle("c");

        // Overflow: a long sequence in service while six drinks arrive back to back.
        send(1'b1, 2'b11, 1'b1);
        quiet();
        for (int n = 0; n < 10 && !busy; n++) @(negedge clk);
        check("d_busy_start", 32'(busy), 1);
        for (int i = 0; i < 6; i++) send(1'b1, 2'b00, i < 4);
        quiet();
        check("d_pending_full", 32'(pending), 4);
        check("d_overflow", 32'(overflow), 1);
        wait_idle("d");
        check("d_overflow_sticky", 32'(overflow), 1);

        // Reset mid-motor with two entries queued.
        for (int i = 0; i < 3; i++) send(1'b1, 2'b00, 1'b1);
        quiet();
        check("e_pending_pre", 32'(pending), 2);
        check("e_motor_pre", 32'(motor), 1);
        #2;
        reset = 1'b0;
        #1;
        check("e_rst_motor", 32'(motor), 0);
        check("e_rst_busy", 32'(busy), 0);
        check("e_rst_pending", 32'(pending), 0);
        check("e_rst_overflow", 32'(overflow), 0);
        sb.delete();
        model_stock = TbStock;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("e_post_busy", 32'(busy), 0);
        check("e_post_pending", 32'(pending), 0);

`ifdef VEND_DISPENSE_SOLDOUT_EN
        // Stock of one: second drink becomes a full refund.
        send(1'b1, 2'b00, 1'b1);
        quiet();
        wait_idle("f1");
        check("f_sold_out", 32'(sold_out), 1);
        send(1'b1, 2'b00, 1'b1);
        quiet();
        @(negedge clk);
        check("f_no_motor", 32'(motor), 0);
        check("f_refund_1y", 32'(eject_1y), 1);
        wait_idle("f2");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
